// File: rtl/fpu_ss_offload_buffer.sv
// Offload-request front end of the FPU subsystem: answers core offload requests from the
// predecoder response and queues accepted instructions in a small FIFO for the decoder.
module fpu_ss_offload_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ID_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,

  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [XLEN-1:0]            in_rs1_i,
  input  logic [ID_W-1:0]            in_id_i,
  output logic                       in_accept_o,
  output logic                       in_writeback_o,

  output logic [31:0]                prd_instr_o,
  input  logic                       prd_accept_i,
  input  logic                       prd_writeback_i,
  input  logic                       prd_is_mem_op_i,
  input  logic [2:0]                 prd_use_rs_i,

  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [XLEN-1:0]            out_rs1_o,
  output logic [ID_W-1:0]            out_id_o,
  output logic                       out_writeback_o,
  output logic                       out_is_mem_op_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] rs1_q   [DEPTH];
  logic [ID_W-1:0] id_q    [DEPTH];
  logic            wb_q    [DEPTH];
  logic            mem_q   [DEPTH];

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ready looks only at registered occupancy, so a full buffer stalls even while it pops.
  assign in_ready_o = !rst_i && !full;

  assign in_accept_o    = in_valid_i && prd_accept_i;
  assign in_writeback_o = in_valid_i && prd_accept_i && prd_writeback_i;
  assign prd_instr_o    = in_instr_i;

  assign push = in_valid_i && in_ready_o && prd_accept_i && !flush_i;
  assign pop  = !empty && out_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; it is only observed while the entry is occupied.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr] <= in_instr_i;
      rs1_q[wr_ptr]   <= prd_use_rs_i[0] ? in_rs1_i : '0;
      id_q[wr_ptr]    <= in_id_i;
      wb_q[wr_ptr]    <= prd_writeback_i;
      mem_q[wr_ptr]   <= prd_is_mem_op_i;
    end
  end

  assign out_valid_o     = !empty;
  assign out_instr_o     = instr_q[rd_ptr];
  assign out_rs1_o       = rs1_q[rd_ptr];
  assign out_id_o        = id_q[rd_ptr];
  assign out_writeback_o = wb_q[rd_ptr];
  assign out_is_mem_op_o = mem_q[rd_ptr];
  assign count_o         = count;

endmodule

// File: tb/tb_fpu_ss_offload_buffer.sv
// Bench for fpu_ss_offload_buffer: directed scenarios plus random traffic, all checked
// against a queue-based reference of the offload buffer.
module tb_fpu_ss_offload_buffer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_instr_i, in_rs1_i;
  logic [3:0]  in_id_i;
  logic        in_accept_o, in_writeback_o;
  logic [31:0] prd_instr_o;
  logic        prd_accept_i, prd_writeback_i, prd_is_mem_op_i;
  logic [2:0]  prd_use_rs_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_instr_o, out_rs1_o;
  logic [3:0]  out_id_o;
  logic        out_writeback_o, out_is_mem_op_o;
  logic [2:0]  count_o;

  fpu_ss_offload_buffer #(.DEPTH(DEPTH), .XLEN(32), .ID_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i),
    .in_rs1_i(in_rs1_i), .in_id_i(in_id_i), .in_accept_o(in_accept_o),
    .in_writeback_o(in_writeback_o), .prd_instr_o(prd_instr_o),
    .prd_accept_i(prd_accept_i), .prd_writeback_i(prd_writeback_i),
    .prd_is_mem_op_i(prd_is_mem_op_i), .prd_use_rs_i(prd_use_rs_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
    .out_rs1_o(out_rs1_o), .out_id_o(out_id_o), .out_writeback_o(out_writeback_o),
    .out_is_mem_op_o(out_is_mem_op_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [3:0]  id;
    logic        wb;
    logic        mem;
  } ent_t;

  ent_t mq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   armed  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive, check against the reference, then advance the reference.
  task automatic step(input bit rst, input bit flush, input bit valid,
                      input logic [31:0] instr, input logic [31:0] rs1, input logic [3:0] id,
                      input bit pa, input bit pwb, input bit pmem, input logic [2:0] puse,
                      input bit ordy);
    bit   exp_ready;
    ent_t e;
    rst_i = rst; flush_i = flush; in_valid_i = valid; in_instr_i = instr;
    in_rs1_i = rs1; in_id_i = id; prd_accept_i = pa; prd_writeback_i = pwb;
    prd_is_mem_op_i = pmem; prd_use_rs_i = puse; out_ready_i = ordy;
    @(negedge clk_i);
    exp_ready = !rst && (mq.size() != DEPTH);
    chk("accept", in_accept_o, valid && pa);
    chk("writeback", in_writeback_o, valid && pa && pwb);
    chk("prd_instr", prd_instr_o, instr);
    if (armed) begin
      chk("in_ready", in_ready_o, exp_ready);
      chk("count", count_o, mq.size());
      chk("out_valid", out_valid_o, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("head_instr", out_instr_o, mq[0].instr);
        chk("head_rs1", out_rs1_o, mq[0].rs1);
        chk("head_id", out_id_o, mq[0].id);
        chk("head_wb", out_writeback_o, mq[0].wb);
        chk("head_mem", out_is_mem_op_o, mq[0].mem);
      end
    end
    @(posedge clk_i);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (valid && exp_ready && pa) begin
        e.instr = instr; e.rs1 = puse[0] ? rs1 : 32'h0; e.id = id; e.wb = pwb; e.mem = pmem;
        if (mq.size() != 0 && ordy) void'(mq.pop_front());
        mq.push_back(e);
      end else if (mq.size() != 0 && ordy) begin
        void'(mq.pop_front());
      end
    end
    if (rst) armed = 1;
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 3'b000, ordy);
  endtask

  initial begin
    // reset held two cycles
    step(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 3'b000, 0);
    step(1, 0, 1, 32'h00208053, 32'h1, 4'h1, 1, 0, 0, 3'b001, 0);
    idle(0);

    // FADD.S accepted, rs1 unused so masked to zero
    step(0, 0, 1, 32'h00208053, 32'hDEADBEEF, 4'h3, 1, 0, 0, 3'b000, 0);
    chk("fadd_valid", out_valid_o, 1);
    chk("fadd_instr", out_instr_o, 32'h00208053);
    chk("fadd_rs1", out_rs1_o, 32'h0);
    chk("fadd_id", out_id_o, 4'h3);
    idle(1);

    // ADD rejected, FMV.X.W writes back
    step(0, 0, 1, 32'h00000033, 32'h5, 4'h4, 0, 0, 0, 3'b001, 0);
    chk("reject_count", count_o, 0);
    step(0, 0, 1, 32'hE0000553, 32'h0, 4'h5, 1, 1, 0, 3'b000, 0);
    chk("fmv_head_wb", out_writeback_o, 1);
    idle(1);

    // fill with FLW, fifth request stalls, then drain
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'h00052007, 32'h100 + i, 4'(i), 1, 0, 1, 3'b001, 0);
    chk("full_count", count_o, 4);
    chk("full_ready", in_ready_o, 0);
    step(0, 0, 1, 32'h00052007, 32'h104, 4'h4, 1, 0, 1, 3'b001, 0);
    chk("stall_count", count_o, 4);
    chk("first_out_rs1", out_rs1_o, 32'h100);
    chk("first_out_mem", out_is_mem_op_o, 1);
    step(0, 0, 1, 32'h00052007, 32'h104, 4'h4, 1, 0, 1, 3'b001, 1);
    for (int i = 0; i < 4; i++) idle(1);

    // steady push+pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++)
      step(0, 0, 1, 32'h1000 + i, 32'h200 + i, 4'(i), 1, 0, 0, 3'b001, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 32'h2000 + i, 32'h300 + i, 4'(i + 2), 1, i[0], 0, 3'b001, 1);
    chk("pp_count", count_o, 2);
    for (int i = 0; i < 3; i++) idle(1);

    // flush at count 3 with a same-cycle push
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 32'h3000 + i, 32'h400 + i, 4'(i), 1, 0, 0, 3'b001, 0);
    step(0, 1, 1, 32'h3003, 32'h403, 4'h3, 1, 0, 0, 3'b001, 1);
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    idle(0);

    // reset mid-operation
    for (int i = 0; i < 2; i++)
      step(0, 0, 1, 32'h4000 + i, 32'h500 + i, 4'(i), 1, 0, 0, 3'b001, 0);
    step(1, 0, 1, 32'h4002, 32'h502, 4'h2, 1, 0, 0, 3'b001, 0);
    chk("rst_count", count_o, 0);

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
           $urandom, $urandom, 4'($urandom), $urandom_range(9) < 7, 1'($urandom),
           1'($urandom), 3'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
